fir_term_sched: RTL and testbench

Time-multiplexed controller for the 10-tap shift-add FIR. It accepts one 32-bit sample at a time and stores it in a 10-entry circular history. It then issues the filter's 29 signed power-of-two terms one per cycle to a single shared add/subtract unit, and returns the result through a valid/ready output. It replaces the fully parallel adder tree plus delay line where area matters more than throughput.

---
 rtl/fir_sched_pkg.sv | 54 +++++
 rtl/fir_term_sched_addsub_w.sv | 17 +
 rtl/fir_term_sched.sv | 93 +++++++++
 tb/tb_fir_term_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// Shared constants, state type and term table
// for the time-multiplexed shift-add FIR.
package fir_sched_pkg;

  localparam int W      = 32;
  localparam int NTAPS  = 10;
  localparam int NTERMS = 29;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [3:0] TERM_TAP [NTERMS] = '{
    4'd0, 4'd0,
    4'd1, 4'd1, 4'd1, 4'd1, 4'd1,
    4'd2, 4'd2, 4'd2,
    4'd3, 4'd3,
    4'd4, 4'd4, 4'd4,
    4'd5, 4'd5, 4'd5,
    4'd6, 4'd6,
    4'd7, 4'd7, 4'd7, 4'd7,
    4'd8, 4'd8, 4'd8,
    4'd9, 4'd9
  };

  localparam logic [3:0] TERM_SHIFT [NTERMS] = '{
    4'd7, 4'd0,
    4'd9, 4'd8, 4'd5, 4'd4, 4'd0,
    4'd9, 4'd6, 4'd4,
    4'd6, 4'd4,
    4'd6, 4'd4, 4'd0,
    4'd6, 4'd4, 4'd1,
    4'd4, 4'd0,
    4'd7, 4'd5, 4'd2, 4'd0,
    4'd7, 4'd5, 4'd0,
    4'd7, 4'd0
  };

  localparam logic TERM_SUB [NTERMS] = '{
    1'b0, 1'b0,
    1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
    1'b0, 1'b0, 1'b0,
    1'b0, 1'b0,
    1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b1,
    1'b1, 1'b0,
    1'b1, 1'b0, 1'b0, 1'b1,
    1'b0, 1'b1, 1'b1,
    1'b0, 1'b1
  };

endpackage

// File: rtl/fir_term_sched_addsub_w.sv
// Shared W-bit add/subtract unit, wraps mod 2^W.
// Subtraction is a + ~b + 1.
module addsub_w #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  // single adder with inverted operand and carry-in
  always_comb begin
    sum = a + (sub ? ~b : b) + W'(sub);
  end

endmodule

// File: rtl/fir_term_sched.sv
// Time-multiplexed FIR controller: one
// signed power-of-two term per cycle.
module fir_term_sched
  import fir_sched_pkg::*;
#(
  parameter int W     = fir_sched_pkg::W,
  parameter int NTAPS = fir_sched_pkg::NTAPS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         flush,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy
);

  state_t       state;
  logic [4:0]   t;
  logic [3:0]   wp;
  logic [W-1:0] acc;
  logic [W-1:0] hist [NTAPS];

  logic [4:0]   rel;
  logic [3:0]   idx;
  logic [W-1:0] addend;
  logic [W-1:0] sum;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  // newest sample sits at wp-1; tap k is k slots older
  always_comb begin
    rel = {1'b0, wp} + 5'd9 - {1'b0, TERM_TAP[t]};
    idx = (rel >= 5'd10) ? 4'(rel - 5'd10) : rel[3:0];
    addend = hist[idx] << TERM_SHIFT[t];
  end

  addsub_w #(.W(W)) u_addsub (
    .a   (acc),
    .b   (addend),
    .sub (TERM_SUB[t]),
    .sum (sum)
  );

  // controller FSM with history, accumulator and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      t        <= '0;
      wp       <= '0;
      acc      <= '0;
      out_data <= '0;
      for (int i = 0; i < NTAPS; i++)
        hist[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (flush) begin
            wp <= '0;
            for (int i = 0; i < NTAPS; i++)
              hist[i] <= '0;
          end else if (in_valid) begin
            hist[wp] <= in_data;
            wp    <= (wp == 4'(NTAPS - 1)) ? '0 : wp + 4'd1;
            acc   <= '0;
            t     <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          acc <= sum;
          if (t == 5'(NTERMS - 1)) begin
            out_data <= sum;
            state    <= OUT;
          end else begin
            t <= t + 5'd1;
          end
        end
        OUT: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_term_sched.sv
// Randomized and directed bench for fir_term_sched
// against a direct-convolution reference model.
module tb_fir_term_sched;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         flush;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;

  int checks;
  int failures;

  int signed    h [10] = '{129, 721, 592, 80, 81,
                           78, -15, -93, 95, 127};
  logic [W-1:0] mh [10];

  fir_term_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 10; k++) mh[k] = '0;
  endtask

  task automatic model_push(input logic [W-1:0] x);
    for (int k = 9; k > 0; k--) mh[k] = mh[k-1];
    mh[0] = x;
  endtask

  function automatic logic [W-1:0] model_y();
    logic [W-1:0] y;
    y = '0;
    for (int k = 0; k < 10; k++)
      y = y + W'(h[k]) * mh[k];
    return y;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk({tag, "_rdy_to"}, 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [W-1:0] x);
    wait_ready("send");
    in_valid = 1'b1;
    in_data  = x;
    @(negedge clk);
    in_valid = 1'b0;
    model_push(x);
  endtask

  task automatic recv(input string tag,
                      input logic [W-1:0] exp,
                      input int hold);
    int n;
    logic [W-1:0] first;
    logic bad;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk({tag, "_vld_to"}, 32'(out_valid), 32'd1);
      return;
    end
    chk(tag, out_data, exp);
    first = out_data;
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || !busy || out_data !== first)
        bad = 1'b1;
    end
    if (hold > 0) chk({tag, "_hold"}, 32'(bad), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  logic [W-1:0] imp [10] = '{32'd129, 32'd721, 32'd592, 32'd80,
                             32'd81, 32'd78, 32'hFFFFFFF1,
                             32'hFFFFFFA3, 32'd95, 32'd127};

  initial begin
    checks    = 0;
    failures  = 0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    model_clear();
    @(negedge clk);
    chk("rst_state", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("rst_data", out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // impulse
    for (int i = 0; i < 10; i++) begin
      send(i == 0 ? 32'd1 : 32'd0);
      recv($sformatf("imp%0d", i), imp[i], 0);
    end
    send(32'd0);
    recv("imp10", 32'd0, 0);

    // step after reset
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send(32'd1);
      recv($sformatf("step%0d", i), model_y(), 0);
    end
    chk("step_const", model_y(), 32'd1795);

    // wrap
    do_reset();
    send(32'h7FFFFFFF);
    recv("wrap", 32'h7FFFFF7F, 0);

    // back-pressure
    send(32'd5);
    recv("bp", model_y(), 20);
    send(32'd3);
    recv("bp_next", model_y(), 0);

    // reset mid-ACC
    send(32'd7);
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstacc", {29'd0, out_valid, busy, 1'b0}, 32'd0);
    chk("rstacc_d", out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    chk("rstacc_rdy", 32'(in_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      send(i == 0 ? 32'd1 : 32'd0);
      recv($sformatf("rimp%0d", i), imp[i], 0);
    end

    // flush
    for (int i = 0; i < 10; i++) begin
      send(32'd1);
      recv("fl_pre", model_y(), 0);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
    send(32'd2);
    recv("flush", 32'd258, 0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd99;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    chk("fl_vld", {30'd0, in_ready, busy}, 32'b10);
    send(32'd2);
    recv("fl_vld_y", 32'd258, 0);

    // randomized
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(7) == 0) begin
        wait_ready("rflush");
        flush    = 1'b1;
        in_valid = 1'($urandom_range(1));
        in_data  = $urandom;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        model_clear();
      end
      send($urandom);
      recv($sformatf("rnd%0d", i), model_y(), $urandom_range(3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
